// File: rtl/sort4_seq_ctrl_if.sv
// Handshake and sorter-port bundle for sort4_seq_ctrl.
// The master modport is the sequencer side; the slave modport is the producer/consumer/sorter side.
interface sort4_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] srt_a;
  logic [WIDTH-1:0] srt_b;
  logic [WIDTH-1:0] srt_c;
  logic [WIDTH-1:0] srt_d;
  logic [WIDTH-1:0] srt_ra;
  logic [WIDTH-1:0] srt_rb;
  logic [WIDTH-1:0] srt_rc;
  logic [WIDTH-1:0] srt_rd;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [7:0]       frame_cnt;

  modport master (
    input  clr, in_data, in_valid, srt_ra, srt_rb, srt_rc, srt_rd, out_ready,
    output in_ready, srt_a, srt_b, srt_c, srt_d, out_data, out_valid, out_last, frame_cnt
  );

  modport slave (
    output clr, in_data, in_valid, srt_ra, srt_rb, srt_rc, srt_rd, out_ready,
    input  in_ready, srt_a, srt_b, srt_c, srt_d, out_data, out_valid, out_last, frame_cnt
  );
endinterface

// File: rtl/sort4_seq_ctrl.sv
// Sequencer time-sharing one external combinational 4-input sorter across a serial word stream.
// Define SORT4_SEQ_DESC_EN to drain each frame in descending order (r3..r0).
module sort4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  sort4_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            loadIdx_q, loadIdx_d;
  logic [1:0]            drainIdx_q, drainIdx_d;
  logic [3:0][WIDTH-1:0] opnd_q, opnd_d;
  logic [3:0][WIDTH-1:0] res_q, res_d;
  logic [7:0]            frameCnt_q, frameCnt_d;
  logic [1:0]            drainSel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      loadIdx_q  <= '0;
      drainIdx_q <= '0;
      opnd_q     <= '0;
      res_q      <= '0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      loadIdx_q  <= loadIdx_d;
      drainIdx_q <= drainIdx_d;
      opnd_q     <= opnd_d;
      res_q      <= res_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  // Two-bit indices wrap 3 -> 0 on their own, which closes each load and drain pass.
  always_comb begin
    state_d    = state_q;
    loadIdx_d  = loadIdx_q;
    drainIdx_d = drainIdx_q;
    opnd_d     = opnd_q;
    res_d      = res_q;
    frameCnt_d = frameCnt_q;
    if (bus.clr) begin
      state_d    = LOAD;
      loadIdx_d  = '0;
      drainIdx_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.in_valid) begin
            opnd_d[loadIdx_q] = bus.in_data;
            loadIdx_d         = loadIdx_q + 2'd1;
            if (loadIdx_q == 2'd3) begin
              state_d = SORT;
            end
          end
        end
        SORT: begin
          res_d      = {bus.srt_rd, bus.srt_rc, bus.srt_rb, bus.srt_ra};
          drainIdx_d = '0;
          state_d    = DRAIN;
        end
        DRAIN: begin
          if (bus.out_ready) begin
            drainIdx_d = drainIdx_q + 2'd1;
            if (drainIdx_q == 2'd3) begin
              frameCnt_d = frameCnt_q + 8'd1;
              state_d    = LOAD;
            end
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

`ifdef SORT4_SEQ_DESC_EN
  assign drainSel = 2'd3 - drainIdx_q;
`else
  assign drainSel = drainIdx_q;
`endif

  // in_ready is held low during reset so no word is consumed before the block is live.
  assign bus.in_ready  = (state_q == LOAD) && !rst;
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = (state_q == DRAIN) && (drainIdx_q == 2'd3);
  assign bus.out_data  = (state_q == DRAIN) ? res_q[drainSel] : '0;
  assign bus.srt_a     = opnd_q[0];
  assign bus.srt_b     = opnd_q[1];
  assign bus.srt_c     = opnd_q[2];
  assign bus.srt_d     = opnd_q[3];
  assign bus.frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Self-checking bench for sort4_seq_ctrl: directed and randomized frames against a queue-based model.
// Build with SORT4_SEQ_DESC_EN defined to check the descending drain order.
module tb_sort4_seq_ctrl;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   orMode   = 0;
  int   orPhase  = 0;

  sort4_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sort4_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sortAsc(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
    logic [3:0] v[4];
    logic [3:0] t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return {v[3], v[2], v[1], v[0]};
  endfunction

  // External sorter stand-in
  logic [15:0] envSorted;
  assign envSorted  = sortAsc(bus.srt_a, bus.srt_b, bus.srt_c, bus.srt_d);
  assign bus.srt_ra = envSorted[3:0];
  assign bus.srt_rb = envSorted[7:4];
  assign bus.srt_rc = envSorted[11:8];
  assign bus.srt_rd = envSorted[15:12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame-level view with a word count, a sort-pending flag and an output queue
  logic [3:0]  mOps[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0]  mOut[$];
  int          mLoadCnt = 0;
  bit          mPending = 1'b0;
  logic [7:0]  mFrame   = 8'd0;
  logic [15:0] mSorted;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 4; i++) mOps[i] = 4'd0;
        mOut.delete();
        mLoadCnt = 0;
        mPending = 1'b0;
        mFrame   = 8'd0;
      end else if (bus.clr) begin
        mOut.delete();
        mLoadCnt = 0;
        mPending = 1'b0;
      end else if (mPending) begin
        mSorted = sortAsc(mOps[0], mOps[1], mOps[2], mOps[3]);
        for (int i = 0; i < 4; i++) begin
`ifdef SORT4_SEQ_DESC_EN
          mOut.push_back(mSorted[4*(3-i) +: 4]);
`else
          mOut.push_back(mSorted[4*i +: 4]);
`endif
        end
        mPending = 1'b0;
      end else if (mOut.size() > 0) begin
        if (bus.out_ready) begin
          mOut.delete(0);
          if (mOut.size() == 0) mFrame = mFrame + 8'd1;
        end
      end else if (bus.in_valid) begin
        mOps[mLoadCnt] = bus.in_data;
        mLoadCnt++;
        if (mLoadCnt == 4) begin
          mLoadCnt = 0;
          mPending = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("in_ready", bus.in_ready, !rst && !mPending && (mOut.size() == 0));
      checkOutput("out_valid", bus.out_valid, mOut.size() > 0);
      checkOutput("out_last", bus.out_last, mOut.size() == 1);
      if (mOut.size() > 0) checkOutput("out_data", bus.out_data, mOut[0]);
      else if (rst) checkOutput("out_data_rst", bus.out_data, 0);
      checkOutput("frame_cnt", bus.frame_cnt, mFrame);
      checkOutput("srt_a", bus.srt_a, mOps[0]);
      checkOutput("srt_b", bus.srt_b, mOps[1]);
      checkOutput("srt_c", bus.srt_c, mOps[2]);
      checkOutput("srt_d", bus.srt_d, mOps[3]);
    end
  end

  // Output transfer monitor (records the edge at which each word transfers)
  logic [3:0] gotData[$];
  bit         gotLast[$];
  int         gotCyc[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !bus.clr && bus.out_valid && bus.out_ready) begin
        gotData.push_back(bus.out_data);
        gotLast.push_back(bus.out_last);
        gotCyc.push_back(cyc + 1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (orMode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = ((orPhase % 4) == 0) || ((orPhase % 4) == 3);
          orPhase++;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic sendWord(input logic [3:0] w, input int maxGap);
    int guard = 0;
    bit hs    = 1'b0;
    int g;
    if (maxGap > 0) begin
      g = $urandom_range(0, maxGap);
      if (g > 0) begin
        bus.in_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!hs && guard < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!hs) checkOutput("in_handshake_timeout", hs, 1);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input logic [3:0] d, input int maxGap, input bit keepValid);
    sendWord(a, maxGap);
    sendWord(b, maxGap);
    sendWord(c, maxGap);
    sendWord(d, maxGap);
    if (!keepValid) bus.in_valid = 1'b0;
  endtask

  task automatic checkFrame(input string name, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3, output int firstCyc);
    logic [3:0] exp[4];
    int guard = 0;
`ifdef SORT4_SEQ_DESC_EN
    exp = '{e3, e2, e1, e0};
`else
    exp = '{e0, e1, e2, e3};
`endif
    while (gotData.size() < 4 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("%s_count", name), gotData.size(), 4);
    for (int i = 0; i < 4 && i < gotData.size(); i++) begin
      checkOutput($sformatf("%s_word%0d", name, i), gotData[i], exp[i]);
      checkOutput($sformatf("%s_last%0d", name, i), gotLast[i], i == 3);
    end
    firstCyc = (gotCyc.size() > 0) ? gotCyc[0] : -1;
    gotData.delete();
    gotLast.delete();
    gotCyc.delete();
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int first;
    int g;
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_data", bus.out_data, 0);
    checkOutput("reset_frame_cnt", bus.frame_cnt, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", bus.in_ready, 1);

    // Frame A, consumer always ready
    orMode = 0;
    applyStimulus(4'b1010, 4'b1110, 4'b0110, 4'b0011, 0, 1'b0);
    acc = cyc;
    checkFrame("frameA", 4'b0011, 4'b0110, 4'b1010, 4'b1110, first);
    checkOutput("frameA_latency", first - acc, 2);
    checkOutput("frameA_cnt", bus.frame_cnt, 1);

    // Frame A again with consumer stalls
    orMode = 1;
    applyStimulus(4'b1010, 4'b1110, 4'b0110, 4'b0011, 0, 1'b0);
    checkFrame("frameStall", 4'b0011, 4'b0110, 4'b1010, 4'b1110, first);
    checkOutput("frameStall_cnt", bus.frame_cnt, 2);

    // Duplicate values
    orMode = 2;
    applyStimulus(4'b1000, 4'b1000, 4'b0001, 4'b1111, 1, 1'b0);
    checkFrame("frameDup", 4'b0001, 4'b1000, 4'b1000, 4'b1111, first);
    checkOutput("frameDup_cnt", bus.frame_cnt, 3);

    // Abort a partial frame with clr
    orMode = 0;
    sendWord(4'd4, 0);
    sendWord(4'd9, 0);
    bus.in_valid = 1'b0;
    bus.clr      = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    applyStimulus(4'b0111, 4'b0001, 4'b1111, 4'b1101, 0, 1'b0);
    checkFrame("frameClr", 4'b0001, 4'b0111, 4'b1101, 4'b1111, first);
    checkOutput("frameClr_cnt", bus.frame_cnt, 4);
    checkOutput("frameClr_srt_a", bus.srt_a, 4'b0111);
    checkOutput("frameClr_srt_d", bus.srt_d, 4'b1101);

    // Reset in the middle of a drain
    applyStimulus(4'b1010, 4'b1110, 4'b0110, 4'b0011, 0, 1'b0);
    g = 0;
    while (gotData.size() < 2 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("midrst_drained", gotData.size(), 2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_out_last", bus.out_last, 0);
    checkOutput("midrst_frame_cnt", bus.frame_cnt, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gotData.delete();
    gotLast.delete();
    gotCyc.delete();
    applyStimulus(4'd5, 4'd12, 4'd0, 4'd9, 0, 1'b0);
    checkFrame("frameAfterRst", 4'd0, 4'd5, 4'd9, 4'd12, first);
    checkOutput("frameAfterRst_cnt", bus.frame_cnt, 1);

    // 256 random frames from a clean reset: frame_cnt must wrap back to 0
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gotData.delete();
    gotLast.delete();
    gotCyc.delete();
    orMode = 2;
    for (int f = 0; f < 256; f++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2, 1'b1);
    end
    bus.in_valid = 1'b0;
    g = 0;
    while (gotData.size() < 1024 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wrap_words", gotData.size(), 1024);
    checkOutput("wrap_model_cnt", mFrame, 0);
    checkOutput("wrap_frame_cnt", bus.frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort4_seq_ctrl.md
Name: sort4_seq_ctrl

Overview:
- Sequencer that time-shares one combinational 4-input sorter (sort4) across a serial word stream.
- Collects four words over a valid/ready input handshake and drives them onto the sorter inputs.
- Captures the sorter result one cycle later, then drains the four sorted words over a valid/ready output handshake.
- Sits between a serial producer and consumer; the sorter instance is external and connected through the srt_* ports.

Parameters:
- WIDTH, 4, word width in bits. Must match the sorter's data width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort. Discards the partial or in-flight frame and returns to LOAD.
- in_data  input  WIDTH  input word.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- srt_a, srt_b, srt_c, srt_d  output  WIDTH each  registered operands driven to the sorter.
- srt_ra, srt_rb, srt_rc, srt_rd  input  WIDTH each  sorter results; ra <= rb <= rc <= rd, unsigned.
- out_data  output  WIDTH  sorted output word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  high with the 4th word of a frame.
- frame_cnt  output  8  completed frames; wraps 255 -> 0.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=LOAD; load index and drain index = 0.
  - srt_a..srt_d = 0; result registers = 0; frame_cnt = 0.
  - in_ready=0 while rst is high. After reset it is 1, driven from state.
  - out_valid=0, out_last=0, out_data=0.
- Handshake rules:
  - A transfer occurs on a rising edge where valid && ready.
  - in_ready and out_valid are functions of registered state only, with no combinational path from in_valid or out_ready.
  - out_data is held stable while out_valid && !out_ready.
- LOAD state:
  - in_ready=1.
  - Each input transfer writes in_data to operand register[idx] (0->srt_a, 1->srt_b, 2->srt_c, 3->srt_d), then idx++.
  - The transfer at idx=3 sets idx=0 and moves to SORT.
- SORT state (exactly 1 cycle):
  - in_ready=0.
  - srt_ra..srt_rd are registered into result registers r0..r3.
  - Next state is DRAIN with drain index 0.
- DRAIN state:
  - out_valid=1; out_data = r[drain idx]; in_ready=0.
  - Each output transfer increments the drain index.
  - out_last=1 when drain idx=3.
  - The transfer at idx=3 increments frame_cnt, returns to LOAD, and leaves out_valid low in the next cycle.
- Latency:
  - 4th input handshake at edge T.
  - SORT occupies cycle T..T+1.
  - out_valid rises after edge T+1; the first word can transfer at edge T+2.
  - Minimum frame period is 4 load + 1 sort + 4 drain = 9 cycles. There is no overlap between frames.
- Operand registers hold their values after SORT; they are only overwritten by new input transfers.
- clr:
  - Takes precedence over any handshake in the same cycle.
  - Next state is LOAD; both indices = 0; out_valid=0.
  - Operand and result registers are unchanged; frame_cnt is unchanged.
  - An aborted frame is not counted.
- Boundary conditions:
  - in_valid while not in LOAD: ignored; the word is not consumed.
  - out_ready held low in DRAIN: stalls indefinitely with data held.
  - Duplicate values: passed through as the sorter orders them; all 4 words are emitted.
  - rst asserted mid-frame: all state is lost immediately; outputs take their reset values asynchronously.

Optional Feature:
- Macro SORT4_SEQ_DESC_EN.
- Defined: drain order is reversed (r3, r2, r1, r0), giving a descending stream. out_last is still on the 4th transfer.
- Undefined: ascending drain (r0..r3) as specified above.

Test Plan:
- Reset then load 1010, 1110, 0110, 0011 with in_valid continuous and out_ready=1 -> out stream 0011, 0110, 1010, 1110; out_last on 1110; first out_valid 2 cycles after the 4th accept; frame_cnt=1.
- Same frame with out_ready toggling 1,0,0,1,... -> identical sequence, out_data stable during stalls, no dropped or duplicated words, and in_ready=0 throughout the drain.
- Load 1000, 1000, 0001, 1111 -> 0001, 1000, 1000, 1111.
- After two loaded words, pulse clr, then load 0111, 0001, 1111, 1101 -> 0001, 0111, 1101, 1111; frame_cnt increments by exactly 1.
- Assert rst after the 2nd drain transfer -> out_valid=0 immediately, frame_cnt=0; the next frame sorts correctly.
- With SORT4_SEQ_DESC_EN defined, load 1010, 1110, 0110, 0011 -> 1110, 1010, 0110, 0011. Also run 256 frames -> frame_cnt wraps to 0.
